// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register; LW/SW go to data memory via req/ack.
// Optional MEM_STAGE_FWD_EN adds combinational forwarding outputs sourced from MEM/WB.
module mem_stage #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] BUBBLE_IR = 16'hF000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       IR_in,
  input  logic [15:0]       alu_in,
  input  logic [15:0]       store_data_in,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       pc2_in,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              reg_wr_en_in,
  input  logic              flush,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [15:0]       dmem_rdata,
  output logic [15:0]       IR_out,
  output logic [15:0]       alu_out,
  output logic [15:0]       mem_read_val,
  output logic [15:0]       pc_out,
  output logic [15:0]       pc2_out,
  output logic              carry_out,
  output logic              zero_out,
  output logic              reg_wr_en_out
`ifdef MEM_STAGE_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [2:0]        fwd_addr,
  output logic [15:0]       fwd_data
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;

  state_t              state_q;
  logic                req_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [15:0]         hir_q, halu_q, hpc_q, hpc2_q;
  logic                hcarry_q, hzero_q, hwr_q;
  logic [15:0]         ir_q, alu_q, mrv_q, pc_q, pc2_q;
  logic                carry_q, zero_q, wr_q;
  logic                is_mem, accept_mem, live;

  assign is_mem     = in_valid && (IR_in[15:12] == OP_LW || IR_in[15:12] == OP_SW);
  assign accept_mem = is_mem && !flush;
  assign live       = in_valid && !flush;
  assign mem_stall  = (state_q == IDLE) ? accept_mem : ~dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hir_q    <= '0;
      halu_q   <= '0;
      hpc_q    <= '0;
      hpc2_q   <= '0;
      hcarry_q <= 1'b0;
      hzero_q  <= 1'b0;
      hwr_q    <= 1'b0;
      ir_q     <= BUBBLE_IR;
      alu_q    <= '0;
      mrv_q    <= '0;
      pc_q     <= '0;
      pc2_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      // Bubble by default; the branches below override when something retires.
      ir_q    <= BUBBLE_IR;
      alu_q   <= '0;
      mrv_q   <= '0;
      pc_q    <= '0;
      pc2_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      wr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_mem) begin
            hir_q    <= IR_in;
            halu_q   <= alu_in;
            hpc_q    <= pc_in;
            hpc2_q   <= pc2_in;
            hcarry_q <= carry_in;
            hzero_q  <= zero_in;
            hwr_q    <= reg_wr_en_in;
            req_q    <= 1'b1;
            we_q     <= (IR_in[15:12] == OP_SW);
            addr_q   <= alu_in[ADDR_W-1:0];
            wdata_q  <= store_data_in;
            state_q  <= BUSY;
          end else if (live) begin
            ir_q    <= IR_in;
            alu_q   <= alu_in;
            pc_q    <= pc_in;
            pc2_q   <= pc2_in;
            carry_q <= carry_in;
            zero_q  <= zero_in;
            wr_q    <= reg_wr_en_in;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            ir_q    <= hir_q;
            alu_q   <= halu_q;
            mrv_q   <= we_q ? 16'h0000 : dmem_rdata;
            pc_q    <= hpc_q;
            pc2_q   <= hpc2_q;
            carry_q <= hcarry_q;
            zero_q  <= hzero_q;
            wr_q    <= we_q ? 1'b0 : hwr_q;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign IR_out        = ir_q;
  assign alu_out       = alu_q;
  assign mem_read_val  = mrv_q;
  assign pc_out        = pc_q;
  assign pc2_out       = pc2_q;
  assign carry_out     = carry_q;
  assign zero_out      = zero_q;
  assign reg_wr_en_out = wr_q;

`ifdef MEM_STAGE_FWD_EN
  logic [3:0] fwd_op;
  assign fwd_op = ir_q[15:12];

  always_comb begin
    fwd_valid = wr_q && (fwd_op <= 4'b0100);
    fwd_addr  = ir_q[11:9];
    if (fwd_op == 4'b0001 || fwd_op == 4'b0010) fwd_addr = ir_q[5:3];
    else if (fwd_op == 4'b0000)                 fwd_addr = ir_q[8:6];
    fwd_data = alu_q;
    if (fwd_op == OP_LW)        fwd_data = mrv_q;
    else if (fwd_op == 4'b0011) fwd_data = {7'b0, ir_q[8:0]};
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected retires/requests, monitor and memory responder check.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, carry_in, zero_in, reg_wr_en_in;
  logic [15:0] IR_in, alu_in, store_data_in, pc_in, pc2_in;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] IR_out, alu_out, mem_read_val, pc_out, pc2_out;
  logic        carry_out, zero_out, reg_wr_en_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] ir, alu, mrv, pc, pc2;
    logic        c, z, wr;
  } retire_t;
  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] rdata;
  } req_t;

  retire_t sq[$];
  req_t    rq[$];
  logic    stray = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(16), .BUBBLE_IR(16'hF000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .IR_in(IR_in), .alu_in(alu_in),
    .store_data_in(store_data_in), .pc_in(pc_in), .pc2_in(pc2_in),
    .carry_in(carry_in), .zero_in(zero_in), .reg_wr_en_in(reg_wr_en_in), .flush(flush),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .IR_out(IR_out), .alu_out(alu_out), .mem_read_val(mem_read_val), .pc_out(pc_out),
    .pc2_out(pc2_out), .carry_out(carry_out), .zero_out(zero_out), .reg_wr_en_out(reg_wr_en_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_retire(input logic [15:0] ir, alu, mrv, pc, pc2, input logic c, z, wr);
    retire_t e;
    e = '{ir: ir, alu: alu, mrv: mrv, pc: pc, pc2: pc2, c: c, z: z, wr: wr};
    sq.push_back(e);
  endtask

  task automatic expect_req(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                            input int delay, input logic [15:0] rdata);
    req_t r;
    r.addr = addr; r.we = we; r.wdata = wdata; r.delay = delay; r.rdata = rdata;
    rq.push_back(r);
  endtask

  // Upstream model: presents one instruction (called at a negedge) and holds it while stalled.
  task automatic issue(input logic [15:0] ir, alu, sd, pc, input logic c, z, wr, fl, flbusy,
                       input int exp_stalls);
    int   stalls;
    logic st;
    in_valid = 1'b1; IR_in = ir; alu_in = alu; store_data_in = sd;
    pc_in = pc; pc2_in = pc + 16'd2; carry_in = c; zero_in = z; reg_wr_en_in = wr; flush = fl;
    stalls = 0;
    forever begin
      #4 st = mem_stall;
      @(posedge clk);
      @(negedge clk);
      if (!st) break;
      stalls++;
      if (flbusy) flush = 1'b1;
      if (stalls > 50) begin
        check("stall_timeout", 64'(stalls), 64'(exp_stalls));
        break;
      end
    end
    in_valid = 1'b0; flush = 1'b0;
    check("stall_cycles", 64'(stalls), 64'(exp_stalls));
  endtask

  // Retire monitor: every non-bubble MEM/WB value must match the next expected retire.
  initial begin
    retire_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (IR_out !== 16'hF000) begin
          if (sq.size() == 0) begin
            check("unexpected_retire", {48'd0, IR_out}, 64'hF000);
          end else begin
            e = sq.pop_front();
            check("retire_ir_alu_mrv", {16'd0, IR_out, alu_out, mem_read_val}, {16'd0, e.ir, e.alu, e.mrv});
            check("retire_pc_flags", {29'd0, pc_out, pc2_out, carry_out, zero_out, reg_wr_en_out},
                  {29'd0, e.pc, e.pc2, e.c, e.z, e.wr});
          end
        end else begin
          check("bubble_wr_en", {63'd0, reg_wr_en_out}, 64'd0);
        end
      end
    end
  end

  // Data-memory responder: checks each request, its stability, and acks after the scripted delay.
  initial begin
    req_t r;
    logic in_req = 1'b0, after_ack = 1'b0;
    int   wait_cnt = 0;
    dmem_ack = 1'b0; dmem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (rst) begin
        in_req = 1'b0; after_ack = 1'b0;
        continue;
      end
      if (after_ack) begin
        check("req_drop_after_ack", {63'd0, dmem_req}, 64'd0);
        after_ack = 1'b0;
      end else if (dmem_req && !in_req) begin
        if (rq.size() == 0) begin
          check("unexpected_req", {63'd0, dmem_req}, 64'd0);
        end else begin
          r = rq.pop_front();
          check("req_fields", {31'd0, dmem_we, dmem_addr, dmem_wdata}, {31'd0, r.we, r.addr, r.wdata});
          in_req = 1'b1; wait_cnt = 0;
        end
      end else if (in_req) begin
        check("req_stable", {30'd0, dmem_req, dmem_we, dmem_addr, dmem_wdata},
              {30'd0, 1'b1, r.we, r.addr, r.wdata});
      end
      if (in_req) begin
        if (wait_cnt == r.delay) begin
          dmem_ack = 1'b1; dmem_rdata = r.rdata; in_req = 1'b0; after_ack = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else if (stray) begin
        dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; IR_in = 16'h0; alu_in = 16'h0;
    store_data_in = 16'h0; pc_in = 16'h0; pc2_in = 16'h0;
    carry_in = 1'b0; zero_in = 1'b0; reg_wr_en_in = 1'b0;
    #1;
    check("reset_ir", {48'd0, IR_out}, 64'hF000);
    check("reset_req", {46'd0, dmem_req, dmem_we, dmem_addr}, 64'd0);
    check("reset_wdata_stall", {47'd0, dmem_wdata, mem_stall}, 64'd0);
    check("reset_pipe", {13'd0, alu_out, mem_read_val, pc_out, carry_out, zero_out, reg_wr_en_out}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ADD: latency 1, no stall
    expect_retire(16'h1298, 16'h0007, 16'h0000, 16'h0100, 16'h0102, 1'b0, 1'b1, 1'b1);
    issue(16'h1298, 16'h0007, 16'hAAAA, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    // LW acked after 3 wait cycles
    expect_req(16'h0040, 1'b0, 16'h5555, 3, 16'hBEEF);
    expect_retire(16'h4A80, 16'h0040, 16'hBEEF, 16'h0102, 16'h0104, 1'b1, 1'b0, 1'b1);
    issue(16'h4A80, 16'h0040, 16'h5555, 16'h0102, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    // SW acked in first BUSY cycle: no write-back, no read value
    expect_req(16'h0010, 1'b1, 16'h1234, 0, 16'hDEAD);
    expect_retire(16'h5A80, 16'h0010, 16'h0000, 16'h0104, 16'h0106, 1'b1, 1'b1, 1'b0);
    issue(16'h5A80, 16'h0010, 16'h1234, 16'h0104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    // flushed ADD and flushed LW in IDLE vanish
    issue(16'h0123, 16'h0042, 16'h0000, 16'h0106, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    issue(16'h4C00, 16'h0080, 16'h0000, 16'h0108, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    // flush raised while the LW is BUSY is ignored
    expect_req(16'h0022, 1'b0, 16'h7777, 2, 16'h5A5A);
    expect_retire(16'h4E00, 16'h0022, 16'h5A5A, 16'h010A, 16'h010C, 1'b0, 1'b0, 1'b1);
    issue(16'h4E00, 16'h0022, 16'h7777, 16'h010A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    // back-to-back LW then SW, each acked at once
    expect_req(16'h0030, 1'b0, 16'h0000, 0, 16'h1111);
    expect_retire(16'h4200, 16'h0030, 16'h1111, 16'h0110, 16'h0112, 1'b0, 1'b1, 1'b1);
    expect_req(16'h0032, 1'b1, 16'h2222, 0, 16'h3333);
    expect_retire(16'h5400, 16'h0032, 16'h0000, 16'h0112, 16'h0114, 1'b1, 1'b0, 1'b0);
    issue(16'h4200, 16'h0030, 16'h0000, 16'h0110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    issue(16'h5400, 16'h0032, 16'h2222, 16'h0112, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    // stray ack in IDLE changes nothing
    stray = 1'b1;
    @(negedge clk); @(negedge clk);
    stray = 1'b0;
    expect_retire(16'h3C05, 16'hFFFF, 16'h0000, 16'h0120, 16'h0122, 1'b1, 1'b1, 1'b1);
    issue(16'h3C05, 16'hFFFF, 16'h0000, 16'h0120, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);

    // reset while BUSY aborts the request asynchronously
    expect_req(16'h0050, 1'b0, 16'h0000, 1000, 16'h9999);
    in_valid = 1'b1; IR_in = 16'h4600; alu_in = 16'h0050; store_data_in = 16'h0000;
    pc_in = 16'h0130; pc2_in = 16'h0132; reg_wr_en_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_req_before_abort", {63'd0, dmem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_req_drop", {63'd0, dmem_req}, 64'd0);
    check("abort_ir_stall", {47'd0, IR_out, mem_stall}, {47'd0, 16'hF000, 1'b0});
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    stray = 1'b1;
    @(negedge clk); @(negedge clk);
    stray = 1'b0;
    check("post_abort_stall_req", {62'd0, mem_stall, dmem_req}, 64'd0);
    expect_retire(16'h0A50, 16'h1357, 16'h0000, 16'h0140, 16'h0142, 1'b0, 1'b0, 1'b1);
    issue(16'h0A50, 16'h1357, 16'h0000, 16'h0140, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    n = 0;
    while ((sq.size() != 0 || rq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("retire_queue_drained", 64'(sq.size()), 64'd0);
    check("req_queue_drained", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
